tff_counter: RTL and testbench

- Parametrised synchronous up/down counter built from a chain of toggle cells. Each bit toggles when its carry/borrow condition is true.
- Next-generation toggle-storage block: generalises the single toggle flop to WIDTH bits, with arbitrary modulus, wrap or saturate mode, synchronous load/clear, and terminal-count and overflow flags.
- Used for dividers, event counters and timeouts in the intermediate projects.

---
 rtl/tff_pkg.sv | 22 ++
 rtl/tff_bit.sv | 21 ++
 rtl/tff_counter.sv | 101 ++++++++++
 tb/tb_tff_counter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared types and elaboration helpers for the toggle-cell counter
package tff_pkg;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } count_dir_e;

  // Terminal value MODULUS-1, masked to the counter width.
  function automatic logic [31:0] max_count(input int unsigned width,
                                            input longint unsigned modulus);
    longint unsigned m;
    m = modulus - 64'd1;
    return 32'(m & ((64'd1 << width) - 64'd1));
  endfunction

  function automatic bit is_pow2(input int unsigned width,
                                 input longint unsigned modulus);
    return modulus == (64'd1 << width);
  endfunction

endpackage

// File: rtl/tff_bit.sv
// rtl/tff_bit.sv - single toggle cell with synchronous reset and parallel load
module tff_bit (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - up/down modulo counter built from a chain of toggle cells
module tff_counter
  import tff_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = (64'd1 << WIDTH),
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(max_count(WIDTH, MODULUS));
  localparam bit               IS_POW2 = is_pow2(WIDTH, MODULUS);

  count_dir_e       dir;
  logic             at_tc;
  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] d_vec;
  logic [WIDTH-1:0] clamp_val;
  logic             ld;
  logic             wrap_ev;
  logic             sat_ev;

  assign dir   = count_dir_e'(up_dn);
  assign at_tc = (dir == UP) ? (q == MAX_Q) : (q == '0);
  assign tc    = at_tc;
  assign q_bar = ~q;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    chain    = '0;
    chain[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      chain[i] = chain[i-1] & ((dir == UP) ? q[i-1] : ~q[i-1]);
    end
  end

  always_comb begin
    clamp_val = (load_val > MAX_Q) ? MAX_Q : load_val;
    t_vec     = '0;
    d_vec     = '0;
    ld        = 1'b0;
    wrap_ev   = 1'b0;
    sat_ev    = 1'b0;
    if (clr) begin
      ld = 1'b1;
    end else if (load) begin
      ld    = 1'b1;
      d_vec = clamp_val;
    end else if (en) begin
      if (at_tc && SATURATE) begin
        sat_ev = 1'b1;
      end else begin
        wrap_ev = at_tc;
        // A full-range counter wraps through the toggle chain; other moduli need a load.
        if (at_tc && !IS_POW2) begin
          ld    = 1'b1;
          d_vec = (dir == UP) ? '0 : MAX_Q;
        end else begin
          t_vec = chain;
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_bit u_bit (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[g]),
      .ld  (ld),
      .d   (d_vec[g]),
      .q   (q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= wrap_ev;
      if (wrap_ev || sat_ev) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tff_counter.sv
// tb/tb_tff_counter.sv - randomized and directed bench for tff_counter
module tb_tff_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] q_a, qb_a, q_b, qb_b, q_c, qb_c;
  logic [0:0] q_d, qb_d;
  logic       tc_a, wr_a, ov_a, tc_b, wr_b, ov_b, tc_c, wr_c, ov_c, tc_d, wr_d, ov_d;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: instance 0 = mod16 wrap, 1 = mod10 wrap, 2 = mod10 sat, 3 = 1-bit mod2.
  int mq[4];
  int mo[4];
  int mw[4];
  int modv[4] = '{16, 10, 10, 2};
  int satv[4] = '{0, 0, 1, 0};
  int wid[4]  = '{4, 4, 4, 1};

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .q(q_a), .q_bar(qb_a), .tc(tc_a), .wrap(wr_a), .ovf(ov_a));
  tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .q(q_b), .q_bar(qb_b), .tc(tc_b), .wrap(wr_b), .ovf(ov_b));
  tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .q(q_c), .q_bar(qb_c), .tc(tc_c), .wrap(wr_c), .ovf(ov_c));
  tff_counter #(.WIDTH(1), .MODULUS(2), .SATURATE(1'b0)) u_d (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val[0:0]),
    .q(q_d), .q_bar(qb_d), .tc(tc_d), .wrap(wr_d), .ovf(ov_d));

  function automatic logic [31:0] get_q(input int i);
    case (i)
      0: return {28'd0, q_a};
      1: return {28'd0, q_b};
      2: return {28'd0, q_c};
      default: return {31'd0, q_d};
    endcase
  endfunction

  function automatic logic [31:0] get_qbar(input int i);
    case (i)
      0: return {28'd0, qb_a};
      1: return {28'd0, qb_b};
      2: return {28'd0, qb_c};
      default: return {31'd0, qb_d};
    endcase
  endfunction

  function automatic logic [2:0] get_flags(input int i);
    case (i)
      0: return {tc_a, wr_a, ov_a};
      1: return {tc_b, wr_b, ov_b};
      2: return {tc_c, wr_c, ov_c};
      default: return {tc_d, wr_d, ov_d};
    endcase
  endfunction

  function automatic logic exp_tc(input int i);
    return up_dn ? (mq[i] == modv[i] - 1) : (mq[i] == 0);
  endfunction

  // Advance one clock: the model applies the behavioural rules to the same inputs the DUT sees.
  task automatic tick();
    int lv;
    int top;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      lv = int'(load_val) % (1 << wid[i]);
      if (rst || clr) begin
        mq[i] = 0; mo[i] = 0; mw[i] = 0;
      end else if (load) begin
        mq[i] = (lv >= modv[i]) ? modv[i] - 1 : lv;
        mw[i] = 0;
      end else if (en) begin
        top = up_dn ? modv[i] - 1 : 0;
        mw[i] = 0;
        if (mq[i] == top) begin
          mo[i] = 1;
          if (satv[i] == 0) begin
            mq[i] = up_dn ? 0 : modv[i] - 1;
            mw[i] = 1;
          end
        end else begin
          mq[i] = up_dn ? mq[i] + 1 : mq[i] - 1;
        end
      end else begin
        mw[i] = 0;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; up_dn = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (get_q(i) !== 32'd0) begin
        n_fail++; $display("FAIL reset_q[%0d]: got %0d expected 0", i, get_q(i));
      end
      n_checks++;
      if (get_qbar(i) !== 32'((1 << wid[i]) - 1)) begin
        n_fail++; $display("FAIL reset_qbar[%0d]: got %0h expected all ones", i, get_qbar(i));
      end
      n_checks++;
      if (get_flags(i) !== 3'b100) begin
        n_fail++; $display("FAIL reset_flags[%0d]: got tc/wrap/ovf %b expected 100", i, get_flags(i));
      end
    end
    set_idle();
  endtask

  task automatic test_count_up_wrap();
    int wraps = 0;
    up_dn = 1'b1; en = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_checks++;
      if (q_a !== 4'(k % 16) || qb_a !== ~4'(k % 16)) begin
        n_fail++; $display("FAIL up16_q step %0d: got %0d/%0h expected %0d", k, q_a, qb_a, k % 16);
      end
      n_checks++;
      if (wr_a !== (k == 16) || ov_a !== (k >= 16)) begin
        n_fail++; $display("FAIL up16_flags step %0d: got wrap %b ovf %b expected %b %b",
                           k, wr_a, ov_a, k == 16, k >= 16);
      end
      if (wr_a === 1'b1) wraps++;
    end
    n_checks++;
    if (wraps != 1) begin
      n_fail++; $display("FAIL up16_wrap_count: got %0d expected 1", wraps);
    end
    set_idle();
  endtask

  task automatic test_down_mod10();
    int exp_seq[5] = '{2, 1, 0, 9, 8};
    clr = 1'b1; tick(); clr = 1'b0;
    up_dn = 1'b0; load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0; en = 1'b1;
    n_checks++;
    if (q_b !== 4'd3) begin
      n_fail++; $display("FAIL down10_load: got %0d expected 3", q_b);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (q_b !== 4'(exp_seq[k]) || tc_b !== (exp_seq[k] == 0)) begin
        n_fail++; $display("FAIL down10_q step %0d: got q %0d tc %b expected %0d %b",
                           k, q_b, tc_b, exp_seq[k], exp_seq[k] == 0);
      end
      n_checks++;
      if (wr_b !== (k == 3)) begin
        n_fail++; $display("FAIL down10_wrap step %0d: got %b expected %b", k, wr_b, k == 3);
      end
    end
    set_idle();
  endtask

  task automatic test_saturate();
    int exp_seq[5] = '{8, 9, 9, 9, 9};
    clr = 1'b1; tick(); clr = 1'b0;
    up_dn = 1'b1; load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (q_c !== 4'(exp_seq[k]) || wr_c !== 1'b0 || ov_c !== (k >= 2)) begin
        n_fail++; $display("FAIL sat10 step %0d: got q %0d wrap %b ovf %b expected %0d 0 %b",
                           k, q_c, wr_c, ov_c, exp_seq[k], k >= 2);
      end
    end
    set_idle();
  endtask

  task automatic test_clamp_clr();
    load = 1'b1; load_val = 4'd12;
    tick();
    n_checks++;
    if (q_b !== 4'd9 || q_c !== 4'd9 || ov_c !== 1'b1) begin
      n_fail++; $display("FAIL clamp: got b %0d c %0d ovf %b expected 9 9 1", q_b, q_c, ov_c);
    end
    clr = 1'b1;
    tick();
    n_checks++;
    if (q_b !== 4'd0 || q_c !== 4'd0 || ov_c !== 1'b0 || ov_b !== 1'b0) begin
      n_fail++; $display("FAIL load_clr: got b %0d c %0d ovf %b%b expected 0 0 00", q_b, q_c, ov_b, ov_c);
    end
    set_idle();
  endtask

  task automatic test_rst_priority();
    clr = 1'b1; tick(); clr = 1'b0;
    up_dn = 1'b1; en = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (q_a !== 4'd6) begin
      n_fail++; $display("FAIL pre_rst_q: got %0d expected 6", q_a);
    end
    rst = 1'b1; load = 1'b1; clr = 1'b1; load_val = 4'd5;
    tick();
    n_checks++;
    if (q_a !== 4'd0 || wr_a !== 1'b0 || ov_a !== 1'b0 || ov_b !== 1'b0) begin
      n_fail++; $display("FAIL rst_priority: got q %0d wrap %b ovf %b expected 0 0 0", q_a, wr_a, ov_a);
    end
    set_idle();
  endtask

  task automatic test_width1();
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (q_d !== 1'(k % 2) || wr_d !== (k % 2 == 0)) begin
        n_fail++; $display("FAIL w1_up step %0d: got q %b wrap %b expected %0d %b",
                           k, q_d, wr_d, k % 2, k % 2 == 0);
      end
    end
    for (int k = 7; k <= 14; k++) begin
      up_dn = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (q_d !== 1'(k % 2)) begin
        n_fail++; $display("FAIL w1_dir step %0d: got %b expected %0d", k, q_d, k % 2);
      end
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 99) < 2);
      clr      = ($urandom_range(0, 99) < 5);
      load     = ($urandom_range(0, 99) < 8);
      en       = ($urandom_range(0, 99) < 80);
      up_dn    = ($urandom_range(0, 99) < 60);
      load_val = 4'($urandom);
      tick();
      if ($urandom_range(0, 3) == 0) begin
        up_dn = ~up_dn;
        #1;
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (get_q(i) !== 32'(mq[i]) || get_qbar(i) !== 32'((~mq[i]) & ((1 << wid[i]) - 1))) begin
          n_fail++; $display("FAIL rand_q[%0d] cyc %0d: got %0d/%0h expected %0d", i, n, get_q(i), get_qbar(i), mq[i]);
        end
        n_checks++;
        if (get_flags(i) !== {exp_tc(i), 1'(mw[i]), 1'(mo[i])}) begin
          n_fail++; $display("FAIL rand_flags[%0d] cyc %0d: got tc/wrap/ovf %b expected %b%0d%0d",
                             i, n, get_flags(i), exp_tc(i), mw[i], mo[i]);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mq[i] = 0; mo[i] = 0; mw[i] = 0;
    end
    test_reset();
    test_count_up_wrap();
    test_down_mod10();
    test_saturate();
    test_clamp_clr();
    test_rst_priority();
    test_width1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
